// File: rtl/spec_hist_ckpt_reg.sv
// spec_hist_ckpt_reg: speculative/committed history pair with mispredict restore and in-flight tracking
module spec_hist_ckpt_reg #(
    parameter int ENTRY_W = 10,
    parameter int DEPTH = 16,
    parameter int MAX_INFLIGHT = 8,
    localparam int HW = ENTRY_W * DEPTH,
    localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spec_push,
    input  logic [ENTRY_W-1:0] spec_data,
    output logic               spec_ready,
    input  logic               cmt_push,
    input  logic [ENTRY_W-1:0] cmt_data,
    input  logic               cmt_miss,
    output logic [HW-1:0]      hist_spec,
    output logic [HW-1:0]      hist_commit,
    output logic [CW-1:0]      inflight,
    output logic               recovered,
    output logic               err
);
    logic          acc, dec, err_now;
    logic [HW-1:0] cmt_next, spec_next;
    logic [CW:0]   sum, diff;
    logic [CW-1:0] cnt_next;
    always_comb begin
        spec_ready = inflight < CW'(MAX_INFLIGHT);
        acc        = ~cmt_miss & spec_push & (spec_ready | cmt_push);
        dec        = cmt_push & ~cmt_miss;
        cmt_next   = {cmt_data, hist_commit[HW-1:ENTRY_W]};
        spec_next  = {spec_data, hist_spec[HW-1:ENTRY_W]};
        sum        = {1'b0, inflight} + {{CW{1'b0}}, acc};
        // a commit with nothing in flight must not wrap the counter
        diff       = (dec && sum == '0) ? '0 : sum - {{CW{1'b0}}, dec};
        cnt_next   = cmt_miss ? '0 : diff > (CW+1)'(MAX_INFLIGHT) ? CW'(MAX_INFLIGHT) : diff[CW-1:0];
        err_now    = (spec_push & ~cmt_miss & ~acc)
                   | (cmt_push & ~acc & (inflight == '0))
                   | (cmt_miss & (inflight == '0));
    end
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            hist_spec   <= '0;
            hist_commit <= '0;
            inflight    <= '0;
            recovered   <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (cmt_push) hist_commit <= cmt_next;
            if (cmt_miss) hist_spec <= cmt_push ? cmt_next : hist_commit;
            else if (acc) hist_spec <= spec_next;
            inflight  <= cnt_next;
            recovered <= cmt_miss;
            err       <= err | err_now;
        end
    end
endmodule
